// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit CPU word access over a 16-bit async SRAM as two timed halfword phases
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic req;
    logic active;
    logic drive;
    logic unused_addr_bits;

    assign req = wr_en | rd_en;

    // The data region base (1024) is a multiple of 4, so rebasing the word
    // index alone gives the same result as subtracting from the full address.
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOW;
                    cnt_d   = 4'd0;
                    idx_d   = address[18:2] - 17'd256;
                    wdata_d = write_data;
                    is_wr_d = wr_en;
                end
            end
            S_LOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_HIGH;
                    cnt_d   = 4'd0;
                    if (!is_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 17'd0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM pins are decoded from registered state only, so a reset or a
    // dropped request cannot glitch the strobe mid-phase.
    assign active      = (state_q == S_LOW) || (state_q == S_HIGH);
    assign drive       = active && is_wr_q;
    assign sram_we_n   = !drive;
    assign sram_dq_oe  = drive;
    assign sram_dq_out = !drive ? 16'd0 :
                         (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    assign sram_addr   = active ? {idx_q, state_q == S_HIGH} : 18'd0;

    assign ready     = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
    assign read_data = rdata_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per 16-bit access phase; legal range 0..15.
REQ-002 clk  input  1  rising-edge system clock, shared with the pipeline.
REQ-003 rst  input  1  reset; one clock; rst is asynchronous and active-low.
REQ-004 wr_en  input  1  MEM-stage store request, held until ready=1.
REQ-005 rd_en  input  1  MEM-stage load request, held until ready=1.
REQ-006 address  input  32  CPU byte address; data region starts at 1024.
REQ-007 write_data  input  32  store data.
REQ-008 read_data  output  32  load result.
REQ-009 ready  output  1  0 = pipeline must freeze; 1 = access complete or no access pending.
REQ-010 sram_addr  output  18  SRAM halfword address.
REQ-011 sram_dq_out  output  16  SRAM write data.
REQ-012 sram_dq_oe  output  1  1 = drive SRAM data bus.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-015 FSM states SHALL be IDLE, LOW, HIGH, DONE; a 4-bit wait counter times each phase.
REQ-016 In IDLE with wr_en|rd_en=1, the block SHALL latch address, write_data and request type, then go to LOW on the next edge; wr_en and rd_en both 1 SHALL be treated as a write.
REQ-017 Word index SHALL be ((address - 1024) mod 2^32)[18:2]; sram_addr = {index, 0} in LOW and {index, 1} in HIGH; out-of-range addresses SHALL wrap with no error.
REQ-018 LOW and HIGH SHALL each last exactly WAIT_CYCLES+1 cycles; the counter resets to 0 on every phase entry.
REQ-019 Write: sram_we_n=0 and sram_dq_oe=1 throughout LOW and HIGH; sram_dq_out = latched data[15:0] in LOW and [31:16] in HIGH.
REQ-020 Read: sram_we_n=1 and sram_dq_oe=0; sram_dq_in SHALL be captured into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-021 In IDLE, DONE, and throughout any read: sram_we_n=1 and sram_dq_oe=0; sram_dq_out SHALL be 0 whenever sram_dq_oe=0.
REQ-022 SRAM-side outputs SHALL depend only on state, counter and latched values, never on live inputs.
REQ-023 ready SHALL equal 0 in IDLE when a request is present, 0 in LOW and HIGH, and 1 in DONE or in IDLE with no request.
REQ-024 DONE SHALL last one cycle and return unconditionally to IDLE; a request still asserted during DONE SHALL NOT start a new access.
REQ-025 Freeze latency: ready=0 for exactly 1+2*(WAIT_CYCLES+1) consecutive cycles per access (5 cycles at the default).
REQ-026 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT change it.
REQ-027 Requests deasserted mid-access SHALL be ignored; the access completes on latched values.
REQ-028 A request in the IDLE cycle directly after DONE SHALL be accepted as a new access (back-to-back).

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, counter 0, latches 0, read_data 0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0 and sram_addr=0.
REQ-030 After reset, ready SHALL be 1 until a request is present.
REQ-031 Reset asserted mid-access SHALL abort the access immediately with no further SRAM strobes.
REQ-032 After rst deasserts, an access SHALL start only on a fresh IDLE acceptance.

Verification
REQ-033 Write 0xDEADBEEF to address 1024 (WAIT_CYCLES=1): ready low for 5 cycles; sram_addr 0 with dq 0xBEEF for 2 cycles, then sram_addr 1 with dq 0xDEAD for 2 cycles; sram_we_n low for 4 cycles.
REQ-034 Read from address 1028 with an SRAM model holding 0x1234 at address 2 and 0xABCD at address 3: read_data=0xABCD1234 when ready rises.
REQ-035 wr_en and rd_en held high through DONE: exactly one write occurs; ready=1 for one cycle; a new write starts the following cycle.
REQ-036 Reset pulse during HIGH of a write: sram_we_n=1 and sram_dq_oe=0 immediately; ready=1 after release; no SRAM activity until the next request.
REQ-037 WAIT_CYCLES=0, then WAIT_CYCLES=3: ready-low duration is 3 and 9 cycles respectively.
REQ-038 Address 0 (below the data region): index wraps to 0x1FF00; sram_addr 0x3FE00 (LOW) then 0x3FE01 (HIGH).
